// File: rtl/pet_kbd_pkg.sv
// Shared types, PS/2 protocol constants and scan-code keymaps for the PET keyboard bridge.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pet_kbd_pkg;

    // One keymap entry: valid flag plus PET matrix coordinates.
    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic [2:0] col;
    } keymap_entry_t;

    // Scan-code parser states: prefix bytes seen so far for the current key.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } parse_state_t;

    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERRF   = 8'hFF;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam int         NUM_ROWS   = 10;

    // Set-2 scan codes without the E0 prefix.
    function automatic keymap_entry_t keymap_norm(input logic [7:0] code);
        keymap_entry_t e;
        e = '0;
        case (code)
            8'h1C:   e = '{valid: 1'b1, row: 4'd4, col: 3'd0};  // A
            8'h5A:   e = '{valid: 1'b1, row: 4'd6, col: 3'd5};  // Return
            8'h12:   e = '{valid: 1'b1, row: 4'd8, col: 3'd0};  // Left shift
            default: e = '0;
        endcase
        return e;
    endfunction

    // Set-2 scan codes that follow an E0 prefix.
    function automatic keymap_entry_t keymap_ext(input logic [7:0] code);
        keymap_entry_t e;
        e = '0;
        case (code)
            8'h75:   e = '{valid: 1'b1, row: 4'd1, col: 3'd7};  // Up -> PET cursor up/down
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host serial receiver: 11-bit frames, odd parity, with inactivity abort.
// Latency: rx_byte/byte_valid (or err) one clk after the stop-bit falling edge is detected.
// Backpressure: none; byte_valid is a single-cycle strobe the consumer must take.
module ps2_rx #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_STAGES = 2      // must be >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;
    logic [3:0]             bit_cnt;
    logic [9:0]             shreg;
    logic [TW-1:0]          tcnt;
    logic [10:0]            full;
    logic                   frame_ok;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    // Complete frame as it would look with the current (11th) bit: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    assign full     = {dat_s, shreg};
    assign frame_ok = ~full[0] & full[10] & (^full[9:1]);

    // Synchronizers preset to the idle-high line level so reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_s;
        end
    end

    // Bit collection, frame check and inactivity abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            tcnt       <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        rx_byte    <= full[8:1];
                        byte_valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end else begin
                    shreg   <= {dat_s, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt <= '0;
                    tcnt    <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_pet_keyboard.sv
// PS/2 keyboard to Commodore PET key matrix bridge: scan-code parser plus 10x8 matrix.
// Latency: matrix update one clk after the byte strobe; keyin is combinational from keyrow.
// Backpressure: none; every received byte is consumed in the cycle it is strobed.
module ps2_pet_keyboard
    import pet_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] keyrow,
    output logic [7:0] keyin,
    output logic       frame_err
);

    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          rx_err;

    parse_state_t  state;
    parse_state_t  state_nxt;
    keymap_entry_t ent;

    logic          upd_vld, upd_vld_nxt;
    logic          upd_set, upd_set_nxt;
    logic [3:0]    upd_row, upd_row_nxt;
    logic [2:0]    upd_col, upd_col_nxt;
    logic          clr_all, clr_all_nxt;

    logic [NUM_ROWS-1:0][7:0] matrix;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .err        (rx_err)
    );

    assign frame_err = rx_err;

    // Parser state and the pending matrix operation it produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            upd_vld <= 1'b0;
            upd_set <= 1'b0;
            upd_row <= '0;
            upd_col <= '0;
            clr_all <= 1'b0;
        end else begin
            state   <= state_nxt;
            upd_vld <= upd_vld_nxt;
            upd_set <= upd_set_nxt;
            upd_row <= upd_row_nxt;
            upd_col <= upd_col_nxt;
            clr_all <= clr_all_nxt;
        end
    end

    // Prefix tracking and key-event decode for each received byte.
    always_comb begin
        state_nxt   = state;
        upd_vld_nxt = 1'b0;
        upd_set_nxt = 1'b0;
        upd_row_nxt = '0;
        upd_col_nxt = '0;
        clr_all_nxt = 1'b0;
        ent = ((state == EXT) || (state == EXT_BRK)) ? keymap_ext(rx_byte)
                                                     : keymap_norm(rx_byte);
        if (byte_valid) begin
            // Any byte not consumed as a prefix ends the sequence.
            state_nxt   = IDLE;
            upd_vld_nxt = ent.valid;
            upd_row_nxt = ent.row;
            upd_col_nxt = ent.col;
            upd_set_nxt = (state == IDLE) || (state == EXT);
            case (state)
                IDLE: begin
                    if (rx_byte == PS2_BRK) begin
                        state_nxt   = BRK;
                        upd_vld_nxt = 1'b0;
                    end else if (rx_byte == PS2_EXT) begin
                        state_nxt   = EXT;
                        upd_vld_nxt = 1'b0;
                    end else if ((rx_byte == PS2_BAT) || (rx_byte == PS2_ERR0) ||
                                 (rx_byte == PS2_ERRF)) begin
                        // Keyboard self-test or overrun: nothing can be trusted as held.
                        clr_all_nxt = 1'b1;
                        upd_vld_nxt = 1'b0;
                    end else if ((rx_byte == PS2_ACK) || (rx_byte == PS2_RESEND) ||
                                 (rx_byte == PS2_ECHO)) begin
                        upd_vld_nxt = 1'b0;
                    end
                end
                EXT: begin
                    if (rx_byte == PS2_BRK) begin
                        state_nxt   = EXT_BRK;
                        upd_vld_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key matrix: bulk clear or single-bit set/clear, one cycle behind the byte strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            matrix <= '0;
        end else if (clr_all) begin
            matrix <= '0;
        end else if (upd_vld && (upd_row < 4'(NUM_ROWS))) begin
            matrix[upd_row][upd_col] <= upd_set;
        end
    end

    // Active-low column read-back for the row the PIA is scanning.
    always_comb begin
        keyin = 8'hFF;
        if (keyrow < 4'(NUM_ROWS)) begin
            keyin = ~matrix[keyrow];
        end
    end

endmodule

// File: doc/ps2_pet_keyboard.md
PS2_PET_KEYBOARD -- requirements
Module: ps2_pet_keyboard

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000: clk cycles without a PS/2 falling edge after which a partial frame is aborted.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on ps2_clk and ps2_data.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-007 keyrow  input  4  PET matrix row select, driven by the PIA1 port A low nibble.
REQ-008 keyin  output  8  PET column bits for the selected row, active-low; drives PIA1 port B.
REQ-009 frame_err  output  1  one-cycle pulse on a parity, start or stop error.

Function
REQ-010 Both PS/2 inputs SHALL pass through SYNC_STAGES flops; data SHALL be sampled on the synchronized ps2_clk falling edge.
REQ-011 The receiver SHALL accept 11-bit frames: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
REQ-012 A frame with a bad start, parity or stop bit SHALL be discarded and pulse frame_err one cycle after the stop-bit edge; parser state SHALL be unchanged.
REQ-013 A partial frame with no falling edge for TIMEOUT_CYC cycles SHALL be aborted silently, and the bit counter SHALL return to 0.
REQ-014 A good frame SHALL raise an internal byte strobe for exactly one cycle, one cycle after the stop-bit edge.
REQ-015 The parser FSM SHALL have four states: IDLE, BRK, EXT, EXT_BRK; reset state is IDLE.
REQ-016 Parser transitions on a byte:
- IDLE + 0xF0 -> BRK
- IDLE + 0xE0 -> EXT
- EXT + 0xF0 -> EXT_BRK
- any other byte -> key event, then IDLE
REQ-017 Key event polarity: IDLE and EXT produce a make; BRK and EXT_BRK produce a break.
REQ-018 Key event table: IDLE and BRK use the normal keymap; EXT and EXT_BRK use the extended keymap.
REQ-019 Each keymap entry SHALL be {valid, row[3:0], col[2:0]}; an invalid entry SHALL be ignored, and the FSM still returns to IDLE.
REQ-020 On a make, matrix bit [row][col] SHALL be set; on a break, it SHALL be cleared; the update SHALL occur on the cycle after the byte strobe.
REQ-021 In IDLE, bytes 0xAA, 0x00 and 0xFF SHALL clear the whole matrix (keyboard reset or overrun); 0xFA, 0xFE and 0xEE SHALL be ignored.
REQ-022 The matrix SHALL be 10 rows x 8 bits of registers.
REQ-023 keyin SHALL be ~matrix[keyrow], combinational from keyrow and the matrix with zero-cycle latency.
REQ-024 keyrow values 10..15 SHALL yield keyin = 0xFF.
REQ-025 If a matrix update and a keyrow change occur in the same cycle, keyin SHALL reflect the pre-update matrix that cycle and the post-update matrix the next cycle.
REQ-026 A make for an already-pressed key and a break for an already-released key SHALL be idempotent.

Reset
REQ-027 Reset SHALL:
- clear the matrix, so keyin = 0xFF for every keyrow;
- set the FSM to IDLE;
- clear the bit counter and timeout counter;
- set frame_err = 0;
- preset the synchronizers to 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the next falling edge after release SHALL be treated as a start bit.

Structure
REQ-029 Package pet_kbd_pkg SHALL hold:
- the keymap entry typedef;
- constants PS2_BRK = 0xF0, PS2_EXT = 0xE0, PS2_BAT = 0xAA, NUM_ROWS = 10;
- functions keymap_norm(byte) and keymap_ext(byte).
REQ-030 Decided keymap entries:
- 0x1C 'A' -> row 4, col 0
- 0x5A Return -> row 6, col 5
- 0x12 LShift -> row 8, col 0
- E0 0x75 Up -> row 1, col 7 (cursor down/up key)
REQ-031 The serial receiver SHALL be a sub-module ps2_rx with outputs byte[7:0], byte_valid and err; the parser and matrix live in ps2_pet_keyboard.

Verification
REQ-032 Frame 0x1C, then keyrow = 4 -> keyin = 0xFE; frames F0 1C -> keyin = 0xFF.
REQ-033 Frames E0 75, keyrow = 1 -> keyin = 0x7F; frames E0 F0 75 -> keyin = 0xFF, and the FSM returns to IDLE.
REQ-034 Frame 0x1C with the parity bit flipped -> frame_err pulse of 1 cycle; the matrix is unchanged, and the next valid 0x5A sets keyin(row 6) = 0xDF.
REQ-035 Six bits of a frame, then a silence of TIMEOUT_CYC+1 cycles, then a full 0x12 frame -> keyin(row 8) = 0xFE with no frame_err.
REQ-036 Keys 0x1C and 0x12 held, then byte 0xAA -> keyin = 0xFF for rows 0..9; keyrow = 12 -> 0xFF at all times.
REQ-037 Reset pulsed after 4 bits of a frame -> a subsequent full frame 0x1C is decoded correctly, and keyin(row 4) = 0xFE.
